// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its output buffer.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_RUN  = 2'd1,
        IFU_HALT = 2'd2
    } ifu_state_e;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned BUF_PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0000_0000;

    // An all-zero word marks unfilled instruction memory.
    function automatic logic is_halt_word(input logic [INSTR_W-1:0] word);
        return word == HALT_WORD;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between fetch and decode; flush overrides push and pop.
module instruction_fetch_unit_fetch_buffer
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [PC_W-1:0]      push_pc,
    input  logic [INSTR_W-1:0]   push_instr,
    input  logic                 pop,
    input  logic                 flush,
    output logic [BUF_CNT_W-1:0] count,
    output logic                 head_valid,
    output logic [PC_W-1:0]      head_pc,
    output logic [INSTR_W-1:0]   head_instr
);

    logic [PC_W-1:0]      pc_q    [BUF_DEPTH];
    logic [INSTR_W-1:0]   instr_q [BUF_DEPTH];
    logic [BUF_PTR_W-1:0] rd_ptr_q;
    logic [BUF_PTR_W-1:0] wr_ptr_q;
    logic [BUF_CNT_W-1:0] count_q;
    logic [BUF_CNT_W-1:0] count_next_c;
    logic                 do_pop_c;
    logic                 do_push_c;

    assign do_pop_c  = pop && (count_q != '0);
    assign do_push_c = push && ((count_q < BUF_CNT_W'(BUF_DEPTH)) || do_pop_c);

    always_comb begin
        count_next_c = count_q;
        unique case ({do_push_c, do_pop_c})
            2'b10:   count_next_c = count_q + BUF_CNT_W'(1);
            2'b01:   count_next_c = count_q - BUF_CNT_W'(1);
            default: count_next_c = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) begin
                pc_q[wr_ptr_q]    <= push_pc;
                instr_q[wr_ptr_q] <= push_instr;
                wr_ptr_q          <= wr_ptr_q + BUF_PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= rd_ptr_q + BUF_PTR_W'(1);
            end
            count_q <= count_next_c;
        end
    end

    // Head is a register-select only; nothing from push/pop reaches it in the same cycle.
    assign count      = count_q;
    assign head_valid = count_q != '0;
    assign head_pc    = pc_q[rd_ptr_q];
    assign head_instr = instr_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, imem read port, redirect/halt FSM and decode handoff buffer.
// Define IFU_PERF_CNT_EN to add the saturating fetch_count port.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               halted
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count
`endif
);

    localparam logic [PC_W-1:0] PC_ALIGN_MASK = ~PC_W'(3);
    localparam logic [PC_W-1:0] RESET_PC_AL   = PC_W'(RESET_PC) & PC_ALIGN_MASK;

    ifu_state_e           state_q;
    logic [PC_W-1:0]      fetch_pc_q;
    logic [BUF_CNT_W-1:0] buf_count;
    logic                 buf_valid;
    logic [PC_W-1:0]      redirect_target_c;
    logic                 pop_c;
    logic                 has_room_c;
    logic                 fetch_fire_c;
    logic                 word_is_halt_c;
    logic                 push_c;

    assign redirect_target_c = redirect_pc & PC_ALIGN_MASK;
    assign pop_c             = buf_valid && out_ready;
    assign has_room_c        = (buf_count < BUF_CNT_W'(BUF_DEPTH)) || pop_c;
    assign fetch_fire_c      = (state_q == IFU_RUN) && !redirect_valid && has_room_c;
    assign word_is_halt_c    = is_halt_word(imem_data);
    assign push_c            = fetch_fire_c && !word_is_halt_c;

    assign imem_addr = {2'b00, fetch_pc_q[PC_W-1:2]};

    // Control FSM with fetch PC and halted flag; redirect outranks everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IFU_IDLE;
            fetch_pc_q <= RESET_PC_AL;
            halted     <= 1'b0;
        end else begin
            unique case (state_q)
                IFU_IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_target_c;
                    end else if (start) begin
                        state_q <= IFU_RUN;
                    end
                end
                IFU_RUN: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_target_c;
                        halted     <= 1'b0;
                    end else if (fetch_fire_c) begin
                        if (word_is_halt_c) begin
                            state_q <= IFU_HALT;
                            halted  <= 1'b1;
                        end else begin
                            fetch_pc_q <= fetch_pc_q + PC_W'(4);
                        end
                    end
                end
                IFU_HALT: begin
                    if (redirect_valid) begin
                        state_q    <= IFU_RUN;
                        fetch_pc_q <= redirect_target_c;
                        halted     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IFU_IDLE;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

    instruction_fetch_unit_fetch_buffer #(
        .PC_W (PC_W)
    ) u_fetch_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_c),
        .push_pc    (fetch_pc_q),
        .push_instr (imem_data),
        .pop        (pop_c),
        .flush      (redirect_valid),
        .count      (buf_count),
        .head_valid (buf_valid),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );

    assign out_valid = buf_valid;

`ifdef IFU_PERF_CNT_EN
    // Saturating count of buffered instructions; redirects leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (push_c && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit against a three-word instruction memory image.
module tb_instruction_fetch_unit;

    localparam int unsigned PC_W = 32;
    localparam logic [31:0] W0 = 32'h4000_0033;
    localparam logic [31:0] W1 = 32'h0000_2083;
    localparam logic [31:0] W2 = 32'h0000_0063;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;
    logic            halted;
`ifdef IFU_PERF_CNT_EN
    logic [31:0]     fetch_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_W     (PC_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] idx);
        case (idx)
            32'd0:   return W0;
            32'd1:   return W1;
            32'd2:   return W2;
            default: return 32'h0;
        endcase
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_pc"},    out_pc,         pc);
        check_eq({tag, "_instr"}, out_instr,      instr);
    endtask

    initial begin
        // Stream: three words back to back, then halt on the zero word.
        do_reset();
        check_eq("rst_valid",  32'(out_valid), 32'd0);
        check_eq("rst_halted", 32'(halted),    32'd0);
        check_eq("rst_addr",   imem_addr,      32'd0);
        check_eq("rst_pc",     out_pc,         32'd0);
        check_eq("rst_instr",  out_instr,      32'd0);
`ifdef IFU_PERF_CNT_EN
        check_eq("rst_count",  fetch_count,    32'd0);
`endif
        out_ready = 1'b1;
        start_run();
        check_eq("s_first_empty", 32'(out_valid), 32'd0);
        tick();
        check_head("s0", 32'd0, W0);
        check_eq("s0_addr", imem_addr, 32'd1);
        tick();
        check_head("s1", 32'd4, W1);
        check_eq("s1_addr", imem_addr, 32'd2);
        tick();
        check_head("s2", 32'd8, W2);
        check_eq("s2_addr", imem_addr, 32'd3);
        tick();
        check_eq("s_halted", 32'(halted),    32'd1);
        check_eq("s_drain",  32'(out_valid), 32'd0);
        check_eq("s_addr3",  imem_addr,      32'd3);
`ifdef IFU_PERF_CNT_EN
        check_eq("s_count",  fetch_count,    32'd3);
`endif

        // Restart from HALT via redirect to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        check_eq("r_halted", 32'(halted),    32'd0);
        check_eq("r_flush",  32'(out_valid), 32'd0);
        check_eq("r_addr",   imem_addr,      32'd0);
        tick();
        check_head("r0", 32'd0, W0);
        tick();
        check_head("r1", 32'd4, W1);
        tick();
        check_head("r2", 32'd8, W2);
        tick();
        check_eq("r_halted2", 32'(halted), 32'd1);
`ifdef IFU_PERF_CNT_EN
        check_eq("r_count",  fetch_count, 32'd6);
`endif

        // Backpressure: fill to two entries, then drain in order.
        do_reset();
        start_run();
        tick();
        tick();
        tick();
        check_eq("b_addr_hold", imem_addr, 32'd2);
        check_head("b_full", 32'd0, W0);
`ifdef IFU_PERF_CNT_EN
        check_eq("b_count", fetch_count, 32'd2);
`endif
        out_ready = 1'b1;
        tick();
        check_head("b1", 32'd4, W1);
        check_eq("b1_addr", imem_addr, 32'd3);
        tick();
        check_head("b2", 32'd8, W2);
        check_eq("b_halted", 32'(halted), 32'd1);
        tick();
        check_eq("b_empty", 32'(out_valid), 32'd0);

        // Redirect with the buffer full to an unaligned target.
        do_reset();
        start_run();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h5;
        tick();
        redirect_valid = 1'b0;
        check_eq("f_flush", 32'(out_valid), 32'd0);
        check_eq("f_addr",  imem_addr,      32'd1);
`ifdef IFU_PERF_CNT_EN
        check_eq("f_count", fetch_count,    32'd2);
`endif
        out_ready = 1'b1;
        tick();
        check_head("f0", 32'd4, W1);
        tick();
        check_head("f1", 32'd8, W2);
        tick();
        check_eq("f_halted", 32'(halted), 32'd1);

        // Async reset between edges, then IDLE behaviour.
        do_reset();
        out_ready = 1'b1;
        start_run();
        tick();
        tick();
        check_head("a_pre", 32'd4, W1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("a_valid",  32'(out_valid), 32'd0);
        check_eq("a_halted", 32'(halted),    32'd0);
        check_eq("a_addr",   imem_addr,      32'd0);
`ifdef IFU_PERF_CNT_EN
        check_eq("a_count",  fetch_count,    32'd0);
`endif
        #2 rst_n = 1'b1;
        tick();
        tick();
        tick();
        check_eq("i_valid", 32'(out_valid), 32'd0);
        check_eq("i_addr",  imem_addr,      32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        tick();
        redirect_valid = 1'b0;
        check_eq("i_redir_addr",  imem_addr,      32'd2);
        check_eq("i_redir_valid", 32'(out_valid), 32'd0);
        tick();
        check_eq("i_still_idle",  32'(out_valid), 32'd0);
        start_run();
        tick();
        check_head("i_run", 32'd8, W2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
